// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: sends a WIDTH-bit word on Q with FRAME/DONE markers.
// Latency: first bit is on Q one enabled edge after the accept; throughput is 1 bit per enabled cycle.
// Backpressure: READY is low while bits remain; LOAD is ignored then. CE=0 freezes every register.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             SR,
    input  logic             SRINIT,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD,
    output logic             READY,
    output logic             Q,
    output logic             FRAME,
    output logic             DONE
);

    // The counter only ever holds WIDTH-1 down to 0.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   sreg_nxt;
    logic [WIDTH-1:0]   sreg_adv;
    logic               q_r;
    logic               q_nxt;
    logic               frame_r;
    logic               frame_nxt;
    logic               done_r;
    logic               done_nxt;
    logic               accept;

    // Bit that goes on the line first for a given register image.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit just sent so the next one moves to the lead position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // READY also opens on the last-bit cycle so a new word follows with no gap.
    assign READY    = (state == ST_IDLE) || (cnt == '0);
    assign accept   = CE && LOAD && READY;
    assign sreg_adv = advance(sreg);

    assign Q     = q_r;
    assign FRAME = frame_r;
    assign DONE  = done_r;

    // Next-state and datapath decode; CE=0 falls through to the hold defaults.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        q_nxt     = q_r;
        frame_nxt = frame_r;
        done_nxt  = done_r;
        if (CE) begin
            if (accept) begin
                // New word: the register keeps the whole word, first bit goes out now.
                state_nxt = ST_SHIFT;
                cnt_nxt   = CNT_LAST;
                sreg_nxt  = D;
                q_nxt     = lead_bit(D);
                frame_nxt = 1'b1;
                // A one-bit word would be its own last bit; WIDTH>=2 keeps this low.
                done_nxt  = (CNT_LAST == '0);
            end else if ((state == ST_SHIFT) && (cnt != '0)) begin
                cnt_nxt   = cnt - CNT_ONE;
                sreg_nxt  = sreg_adv;
                q_nxt     = lead_bit(sreg_adv);
                frame_nxt = 1'b1;
                done_nxt  = (cnt == CNT_ONE);
            end else begin
                // Idle, or the last bit has been sent with no follow-on word.
                state_nxt = ST_IDLE;
                q_nxt     = SRINIT;
                frame_nxt = 1'b0;
                done_nxt  = 1'b0;
            end
        end
    end

    // State and datapath registers; SR wins over CE and LOAD.
    always_ff @(posedge CLK) begin
        if (SR) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sreg    <= '0;
            q_r     <= SRINIT;
            frame_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sreg    <= sreg_nxt;
            q_r     <= q_nxt;
            frame_r <= frame_nxt;
            done_r  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus.
// Each edge is mirrored in a queue-of-bits reference; outputs are compared 1 time unit after the edge.
// Directed scenarios plus a randomized run.
module tb_piso_shift_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         SR;
    logic         SRINIT;
    logic         CE;
    logic         LOAD;
    logic [W-1:0] D;

    logic rdy_m, q_m, frame_m, done_m;
    logic rdy_l, q_l, frame_l, done_l;

    always #5 CLK = ~CLK;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .SR(SR), .SRINIT(SRINIT), .CE(CE), .D(D), .LOAD(LOAD),
        .READY(rdy_m), .Q(q_m), .FRAME(frame_m), .DONE(done_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .SR(SR), .SRINIT(SRINIT), .CE(CE), .D(D), .LOAD(LOAD),
        .READY(rdy_l), .Q(q_l), .FRAME(frame_l), .DONE(done_l)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Reference: remaining bits of the word in flight, plus the registered outputs.
    bit rem_m[$];
    bit rem_l[$];
    bit exp_q[2];
    bit exp_frame[2];
    bit exp_done[2];

    // Apply one clock edge to reference k (0 = MSB-first, 1 = LSB-first).
    task automatic model_edge(input int k);
        bit r[$];
        r = (k == 0) ? rem_m : rem_l;
        if (SR) begin
            r = {};
            exp_q[k] = SRINIT; exp_frame[k] = 1'b0; exp_done[k] = 1'b0;
        end else if (CE) begin
            if (LOAD && r.size() == 0) begin
                r = {};
                for (int i = 0; i < W; i++) r.push_back((k == 0) ? D[W-1-i] : D[i]);
                exp_q[k] = r.pop_front();
                exp_frame[k] = 1'b1;
                exp_done[k] = 1'b0;
            end else if (r.size() > 0) begin
                exp_q[k] = r.pop_front();
                exp_frame[k] = 1'b1;
                exp_done[k] = (r.size() == 0);
            end else begin
                exp_q[k] = SRINIT; exp_frame[k] = 1'b0; exp_done[k] = 1'b0;
            end
        end
        if (k == 0) rem_m = r;
        else        rem_l = r;
    endtask

    // Drive inputs, take one edge, compare both instances against the reference.
    task automatic step(input logic sr_i, input logic srinit_i, input logic ce_i,
                        input logic load_i, input logic [W-1:0] d_i);
        SR = sr_i; SRINIT = srinit_i; CE = ce_i; LOAD = load_i; D = d_i;
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
        chk("msb_q",     {31'd0, q_m},     {31'd0, exp_q[0]});
        chk("msb_frame", {31'd0, frame_m}, {31'd0, exp_frame[0]});
        chk("msb_done",  {31'd0, done_m},  {31'd0, exp_done[0]});
        chk("msb_ready", {31'd0, rdy_m},   {31'd0, rem_m.size() == 0});
        chk("lsb_q",     {31'd0, q_l},     {31'd0, exp_q[1]});
        chk("lsb_frame", {31'd0, frame_l}, {31'd0, exp_frame[1]});
        chk("lsb_done",  {31'd0, done_l},  {31'd0, exp_done[1]});
        chk("lsb_ready", {31'd0, rdy_l},   {31'd0, rem_l.size() == 0});
    endtask

    logic [15:0] qw;
    logic [15:0] lw;
    logic [15:0] dmask;
    int          frames;
    int          dones;

    initial begin
        SR = 1'b1; SRINIT = 1'b1; CE = 1'b0; LOAD = 1'b0; D = '0;

        // Reset, then SRINIT steers the idle level.
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("rst_q",     {31'd0, q_m},     32'd1);
        chk("rst_frame", {31'd0, frame_m}, 32'd0);
        chk("rst_done",  {31'd0, done_m},  32'd0);
        chk("rst_ready", {31'd0, rdy_m},   32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("srinit_follow", {31'd0, q_m}, 32'd0);

        // Single word A5, one-cycle LOAD pulse.
        qw = '0; dmask = '0; frames = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 0), 8'hA5);
            qw = {qw[14:0], q_m};
            dmask = {dmask[14:0], done_m};
            frames += frame_m;
            chk("a5_ready", {31'd0, rdy_m}, {31'd0, (i == 7)});
        end
        chk("a5_bits",   {16'd0, qw},    32'h00A5);
        chk("a5_done",   {16'd0, dmask}, 32'h0001);
        chk("a5_frames", frames,         32'd8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("a5_tail_q", {31'd0, q_m},   32'd1);

        // Back-to-back FF then 00; LOAD held high with D=55 while not ready.
        qw = '0; dmask = '0; frames = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
            else if (i < 8)  step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
            else if (i == 8) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
            else             step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            qw = {qw[14:0], q_m};
            dmask = {dmask[14:0], done_m};
            frames += frame_m;
        end
        chk("b2b_bits",   {16'd0, qw},    32'hFF00);
        chk("b2b_done",   {16'd0, dmask}, 32'h0101);
        chk("b2b_frames", frames,         32'd16);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // CE stall of 3 cycles after the second bit of 81.
        qw = '0; frames = 0;
        for (int i = 0; i < 11; i++) begin
            if (i >= 2 && i <= 4) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                chk("stall_q",     {31'd0, q_m},     32'd0);
                chk("stall_frame", {31'd0, frame_m}, 32'd1);
            end else begin
                step(1'b0, 1'b0, 1'b1, (i == 0), 8'h81);
                qw = {qw[14:0], q_m};
            end
            frames += frame_m;
        end
        chk("stall_bits",   {16'd0, qw}, 32'h0081);
        chk("stall_frames", frames,      32'd11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("stall_end", {31'd0, frame_m}, 32'd0);

        // Mid-word reset on the 4th bit of 3C, CE low in the same cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, (i == 0), 8'h3C);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C);
        chk("abort_ready", {31'd0, rdy_m},   32'd1);
        chk("abort_frame", {31'd0, frame_m}, 32'd0);
        chk("abort_done",  {31'd0, done_m},  32'd0);
        chk("abort_q",     {31'd0, q_m},     32'd1);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            dones += done_m;
        end
        chk("abort_no_done", dones, 32'd0);
        qw = '0; dmask = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, (i == 0), 8'hC3);
            qw = {qw[14:0], q_m};
            dmask = {dmask[14:0], done_m};
        end
        chk("c3_bits", {16'd0, qw},    32'h00C3);
        chk("c3_done", {16'd0, dmask}, 32'h0001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // 01 word: LSB-first line sees 1 then seven 0s, MSB-first sees seven 0s then 1.
        qw = '0; lw = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 0), 8'h01);
            qw = {qw[14:0], q_m};
            lw = {lw[14:0], q_l};
        end
        chk("lsb01_bits", {16'd0, lw}, 32'h0080);
        chk("msb01_bits", {16'd0, qw}, 32'h0001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Randomized traffic against the reference.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1),
                 ($urandom_range(3) != 0), $urandom_range(1), W'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in/serial-out transmitter for the assignment storage-element library. It accepts a WIDTH-bit word on a load handshake and drives it onto a single-bit line, one bit per enabled clock, with frame and done markers. It is the sending end for downstream single-bit capture stages built from CE/SR storage elements. Its control pins keep the library's CE / SR / SRINIT semantics, and its reset is clocked.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1 = send D[WIDTH-1] first, 0 = send D[0] first

Ports:
- CLK  input  1  single clock; all state updates on the rising edge
- SR  input  1  synchronous active-high reset; overrides CE and LOAD
- SRINIT  input  1  reset/idle level driven on Q
- CE  input  1  clock enable; when low, every register holds, including state, counter, Q, FRAME and DONE
- D  input  WIDTH  parallel word to transmit
- LOAD  input  1  word-valid request
- READY  output  1  block can accept a word this cycle
- Q  output  1  serial data, registered
- FRAME  output  1  high while Q carries a data bit, registered
- DONE  output  1  high during the cycle Q carries the last bit, registered

## Operation
- States: IDLE, SHIFT.
- Internal registers: WIDTH-bit shift register, bit counter of clog2(WIDTH) bits, and the state register.
- SR=1 at an edge gives: state=IDLE, counter=0, shift register=0, Q=SRINIT, FRAME=0, DONE=0.
  - SR=1 takes priority over CE=0 and LOAD.
  - SR=1 asserted mid-word aborts the word; no DONE is produced.
- READY is combinational: 1 in IDLE, or in SHIFT when counter==0. Otherwise 0.
- An accept happens at an edge with CE=1, SR=0, LOAD=1 and READY=1.
  - D is captured into the shift register.
  - Q is driven with the first bit, FRAME=1, counter=WIDTH-1, state=SHIFT.
  - DONE=1 only if WIDTH-1==0; this cannot occur, because WIDTH≥2.
- SHIFT, enabled edge, counter>0:
  - Q is driven with the next bit (MSB_FIRST selects the direction) and the counter decrements.
  - When the counter reaches 0, DONE=1 for that bit.
- SHIFT, enabled edge, counter==0 (the last bit has been driven):
  - If LOAD=1, the next word is accepted with no gap, as in an accept from IDLE. FRAME stays 1 and DONE returns to 0.
  - Otherwise: state=IDLE, Q=SRINIT, FRAME=0, DONE=0.
- IDLE, enabled edge with no accept: Q follows the current SRINIT, and FRAME=0, DONE=0.
- LOAD while READY=0 is ignored. D is sampled only on an accept.

## Timing
- Accept at enabled edge k: bits are driven on Q after enabled edges k, k+1, …, k+WIDTH-1, giving WIDTH enabled cycles of data.
- Latency from accept to the first bit on Q is 1 edge.
- FRAME is high for exactly WIDTH enabled cycles per word.
- DONE is high for exactly 1 enabled cycle per word, the last bit cycle.
- CE=0 cycles stretch the frame; each bit stays on Q until the next enabled edge.
- Back-to-back throughput is 1 bit per enabled cycle; FRAME never drops between words loaded on the last-bit cycle.
- Outputs after reset: READY=1, Q=SRINIT, FRAME=0, DONE=0.

## Test plan
- Reset: SR=1, SRINIT=1, then SR=0 with CE=1 and LOAD=0. Required: Q=1, FRAME=0, DONE=0, READY=1. Then SRINIT=0 gives Q=0 one edge later.
- Single word, WIDTH=8, MSB_FIRST=1, D=8'hA5, LOAD pulsed for 1 cycle. Required:
  - Q sequence 1,0,1,0,0,1,0,1 over 8 cycles.
  - FRAME high for 8 cycles.
  - DONE high only on the 8th.
  - READY low for cycles 1-7, high on cycle 8.
  - Q returns to SRINIT afterward.
- Back-to-back: 8'hFF accepted, with LOAD held high and D=8'h00 on the last-bit cycle. Required:
  - 16 consecutive FRAME cycles carrying eight 1s then eight 0s.
  - DONE high on cycles 8 and 16.
  - The LOAD presented while READY=0 during cycles 1-7 is ignored.
- CE stall: D=8'h81, CE=0 for 3 cycles after the 2nd bit. Required: Q holds 0 and FRAME holds 1 for those cycles, and the counter is unchanged. The frame totals 11 cycles, and the bits still read 1,0,0,0,0,0,0,1.
- Mid-word reset: SR=1 asserted on the 4th bit of 8'h3C, with CE=0 in the same cycle. Required: next cycle READY=1, FRAME=0, DONE=0, Q=SRINIT, and no DONE for the aborted word. A following load of 8'hC3 transmits cleanly.
- LSB-first: MSB_FIRST=0, D=8'h01. Required: Q sequence 1,0,0,0,0,0,0,0.
